// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/result bundle between the pipeline controller and the divider
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  q, r, busy, done, div_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output q, r, busy, done, div_zero
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider (DIV/DIVU), one quotient bit per clock
// Signed operands are reduced to magnitudes on entry and the signs are re-applied in FINISH.
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  div_unit_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dmag;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;
  logic [WIDTH:0]   rem_sh;
  logic             fits;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Operand conditioning; negating the most negative value yields itself, which
  // is what makes MIN / -1 come out as MIN with no special case.
  always_comb begin
    a_neg  = bus.is_signed & bus.dividend[WIDTH-1];
    b_neg  = bus.is_signed & bus.divisor[WIDTH-1];
    a_mag  = a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    b_mag  = b_neg ? (~bus.divisor + 1'b1) : bus.divisor;
    b_zero = (bus.divisor == '0);
  end

  // The shifted partial remainder needs one extra bit; the difference always fits in WIDTH.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    fits   = (rem_sh >= {1'b0, dmag});
    diff   = rem_sh[WIDTH-1:0] - dmag;
    q_fix  = neg_q ? (~quo + 1'b1) : quo;
    r_fix  = neg_r ? (~rem + 1'b1) : rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = b_zero ? FINISH : CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_nx = FINISH;
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      dmag         <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      dz           <= 1'b0;
      bus.q        <= '0;
      bus.r        <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            cnt      <= CNT_MAX;
            dmag     <= b_mag;
            // Divide by zero reports the raw dividend, so skip the sign fix-up entirely.
            if (b_zero) begin
              quo   <= '1;
              rem   <= bus.dividend;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              dz    <= 1'b1;
            end else begin
              quo   <= a_mag;
              rem   <= '0;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              dz    <= 1'b0;
            end
          end
        end
        CALC: begin
          rem <= fits ? diff : rem_sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], fits};
          cnt <= cnt - CW'(1);
        end
        FINISH: begin
          bus.q        <= q_fix;
          bus.r        <= r_fix;
          bus.div_zero <= dz;
          bus.done     <= 1'b1;
          bus.busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit: directed corner cases plus random DIV/DIVU traffic
module tb_div_unit;
  localparam int  W  = 32;
  localparam time HP = 5;
  localparam time CP = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #HP clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
    time          t0;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic; 64-bit signed math makes MIN / -1 wrap naturally.
  function automatic exp_t model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa;
    longint      sbv;
    logic [63:0] tq;
    logic [63:0] tr;
    e.t0 = 0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1;
    end else if (!sgn) begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = W + 1;
    end else begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      tq  = sa / sbv;
      tr  = sa % sbv;
      e.q = tq[W-1:0]; e.r = tr[W-1:0]; e.dz = 1'b0; e.lat = W + 1;
    end
    return e;
  endfunction

  // Call at a falling edge; the start is sampled at the following rising edge.
  task automatic issue(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b, input bit accept);
    exp_t e;
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    if (accept) begin
      e    = model(sgn, a, b);
      e.t0 = $time + HP;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  // Returns at the falling edge where done is seen.
  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    @(negedge clk);
    issue(sgn, a, b, 1'b1);
    wait_done(name);
  endtask

  initial begin : monitor
    int   bcnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bcnt = 0;
        check("done_in_reset", {63'd0, bus.done}, 64'd0);
      end else if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("q", {32'd0, bus.q}, {32'd0, e.q});
          check("r", {32'd0, bus.r}, {32'd0, e.r});
          check("div_zero", {63'd0, bus.div_zero}, {63'd0, e.dz});
          check("latency", 64'(($time - e.t0 - HP) / CP), 64'(e.lat));
          check("busy_cycles", 64'(bcnt), 64'(e.lat));
          check("busy_at_done", {63'd0, bus.busy}, 64'd0);
        end
        bcnt = 0;
      end else if (bus.busy) begin
        bcnt++;
      end
    end
  end

  initial begin : driver
    bit           sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    repeat (2) @(negedge clk);
    check("rst_q", {32'd0, bus.q}, 64'd0);
    check("rst_r", {32'd0, bus.r}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_div_zero", {63'd0, bus.div_zero}, 64'd0);
    rst_n = 1'b1;

    run(1'b0, 32'd100, 32'd7, "divu_100_7");
    run(1'b1, -32'sd7, 32'd2, "div_m7_2");
    run(1'b1, 32'd7, -32'sd2, "div_7_m2");
    run(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run(1'b0, 32'd5, 32'd0, "divu_5_0");
    run(1'b0, 32'd9, 32'd3, "divu_9_3");

    // Start while busy is ignored; start in the done cycle is accepted.
    @(negedge clk);
    issue(1'b0, 32'd100, 32'd7, 1'b1);
    repeat (8) @(negedge clk);
    issue(1'b0, 32'd50, 32'd5, 1'b0);
    wait_done("ignored_start");
    issue(1'b0, 32'd50, 32'd5, 1'b1);
    wait_done("back_to_back");

    // Mid-operation reset aborts asynchronously with no done pulse.
    @(negedge clk);
    issue(1'b0, 32'd100, 32'd7, 1'b1);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_q", {32'd0, bus.q}, 64'd0);
    check("abort_r", {32'd0, bus.r}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 32'd20, 32'd6, "after_reset");

    for (int i = 0; i < 150; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = $urandom_range(1, 15);
        2:       b = -($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      issue(sgn, a, b, 1'b1);
      wait_done("random");
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
